// File: rtl/uart_core_if.sv
// Host-side handshake bundle for uart_core: TX FIFO push port, RX FIFO pop port, status flags.
// The master modport is the host; the slave modport is the UART core.
interface uart_core_if #(
    parameter int DATA_BITS = 8
);
    logic                 tx_available;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_ack;
    logic                 tx_busy;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_frame_err;
    logic                 rx_parity_err;
    logic                 rx_pop;
    logic                 rx_ack;
    logic                 rx_valid;
    logic                 rx_overrun;
    logic                 overrun_clr;

    modport master (
        output tx_available, tx_data, rx_pop, overrun_clr,
        input  tx_ack, tx_busy, rx_data, rx_frame_err, rx_parity_err,
               rx_ack, rx_valid, rx_overrun
    );

    modport slave (
        input  tx_available, tx_data, rx_pop, overrun_clr,
        output tx_ack, tx_busy, rx_data, rx_frame_err, rx_parity_err,
               rx_ack, rx_valid, rx_overrun
    );
endinterface

// File: rtl/uart_core.sv
// UART with TX and RX FIFOs, programmable divisor, optional parity and 1/2 stop bits.
// Each direction latches the divisor at frame start so mid-frame divisor changes are harmless.
module uart_core #(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int DIV_WIDTH = 16,
    parameter int TX_FIFO   = 16,
    parameter int RX_FIFO   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIV_WIDTH-1:0] divisor,
    output logic                 uart_tx,
    input  logic                 uart_rx,
    uart_core_if.slave           bus
);
    localparam int TX_AW = $clog2(TX_FIFO);
    localparam int RX_AW = $clog2(RX_FIFO);
    localparam int RX_W  = DATA_BITS + 2;
    localparam logic [DIV_WIDTH-1:0] DIV_ONE = 1;
    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic PAR_ODD = (PARITY == 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic [DATA_BITS-1:0] tx_mem [TX_FIFO];
    logic [TX_AW:0]       tx_wr_ptr;
    logic [TX_AW:0]       tx_rd_ptr;
    logic                 tx_empty;
    logic                 tx_full;
    logic                 tx_pop;
    logic [DATA_BITS-1:0] tx_head;

    state_t               tx_state;
    logic [DATA_BITS-1:0] tx_shift;
    logic [DIV_WIDTH-1:0] tx_div;
    logic [DIV_WIDTH-1:0] tx_cnt;
    logic [3:0]           tx_bit;
    logic                 tx_par;
    logic                 tx_bit_end;

    assign tx_empty   = (tx_wr_ptr == tx_rd_ptr);
    assign tx_full    = (tx_wr_ptr[TX_AW-1:0] == tx_rd_ptr[TX_AW-1:0]) &&
                        (tx_wr_ptr[TX_AW] != tx_rd_ptr[TX_AW]);
    assign tx_head    = tx_mem[tx_rd_ptr[TX_AW-1:0]];
    assign tx_pop     = (tx_state == S_IDLE) && !tx_empty;
    assign tx_bit_end = (tx_cnt == tx_div - DIV_ONE);

    assign bus.tx_ack  = bus.tx_available && !tx_full;
    assign bus.tx_busy = (tx_state != S_IDLE) || !tx_empty;

    always_ff @(posedge clk) begin
        if (bus.tx_ack) begin
            tx_mem[tx_wr_ptr[TX_AW-1:0]] <= bus.tx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
        end else begin
            if (bus.tx_ack) tx_wr_ptr <= tx_wr_ptr + 1'b1;
            if (tx_pop)     tx_rd_ptr <= tx_rd_ptr + 1'b1;
        end
    end

    // uart_tx is registered and changes on the same edge as the state, so each state spans tx_div clocks.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= S_IDLE;
            uart_tx  <= 1'b1;
            tx_shift <= '0;
            tx_div   <= '0;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_par   <= 1'b0;
        end else begin
            tx_cnt <= tx_bit_end ? '0 : tx_cnt + DIV_ONE;
            case (tx_state)
                S_IDLE: begin
                    uart_tx <= 1'b1;
                    tx_cnt  <= '0;
                    tx_bit  <= '0;
                    if (!tx_empty) begin
                        tx_shift <= tx_head;
                        tx_par   <= (^tx_head) ^ PAR_ODD;
                        tx_div   <= divisor;
                        uart_tx  <= 1'b0;
                        tx_state <= S_START;
                    end
                end
                S_START: begin
                    if (tx_bit_end) begin
                        uart_tx  <= tx_shift[0];
                        tx_bit   <= '0;
                        tx_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (tx_bit_end) begin
                        if (tx_bit == LAST_DATA) begin
                            tx_bit <= '0;
                            if (PARITY != 0) begin
                                uart_tx  <= tx_par;
                                tx_state <= S_PARITY;
                            end else begin
                                uart_tx  <= 1'b1;
                                tx_state <= S_STOP;
                            end
                        end else begin
                            tx_shift <= tx_shift >> 1;
                            uart_tx  <= tx_shift[1];
                            tx_bit   <= tx_bit + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (tx_bit_end) begin
                        uart_tx  <= 1'b1;
                        tx_bit   <= '0;
                        tx_state <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (tx_bit_end) begin
                        if (tx_bit == LAST_STOP) begin
                            tx_state <= S_IDLE;
                        end else begin
                            tx_bit <= tx_bit + 1'b1;
                        end
                    end
                end
                default: tx_state <= S_IDLE;
            endcase
        end
    end

    logic rx_meta;
    logic rx_sync;
    logic rx_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    logic [RX_W-1:0]      rx_mem [RX_FIFO];
    logic [RX_AW:0]       rx_wr_ptr;
    logic [RX_AW:0]       rx_rd_ptr;
    logic                 rx_empty;
    logic                 rx_full;
    logic                 rx_push;
    logic                 rx_drop;
    logic [RX_W-1:0]      rx_head;
    logic                 rx_overrun_q;

    state_t               rx_state;
    logic [DATA_BITS-1:0] rx_shift;
    logic [DIV_WIDTH-1:0] rx_div;
    logic [DIV_WIDTH-1:0] rx_cnt;
    logic [3:0]           rx_bit;
    logic                 rx_perr;
    logic                 rx_bit_end;
    logic                 rx_stop_sample;

    assign rx_empty       = (rx_wr_ptr == rx_rd_ptr);
    assign rx_full        = (rx_wr_ptr[RX_AW-1:0] == rx_rd_ptr[RX_AW-1:0]) &&
                            (rx_wr_ptr[RX_AW] != rx_rd_ptr[RX_AW]);
    assign rx_bit_end     = (rx_cnt == rx_div - DIV_ONE);
    assign rx_stop_sample = (rx_state == S_STOP) && rx_bit_end;
    assign rx_push        = rx_stop_sample && !rx_full;
    assign rx_drop        = rx_stop_sample && rx_full;
    assign rx_head        = rx_mem[rx_rd_ptr[RX_AW-1:0]];

    assign bus.rx_valid      = !rx_empty;
    assign bus.rx_ack        = bus.rx_pop && !rx_empty;
    assign bus.rx_data       = rx_head[DATA_BITS-1:0];
    assign bus.rx_frame_err  = rx_head[DATA_BITS];
    assign bus.rx_parity_err = rx_head[DATA_BITS+1];
    assign bus.rx_overrun    = rx_overrun_q;

    always_ff @(posedge clk) begin
        if (rx_push) begin
            rx_mem[rx_wr_ptr[RX_AW-1:0]] <= {rx_perr, !rx_sync, rx_shift};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_wr_ptr    <= '0;
            rx_rd_ptr    <= '0;
            rx_overrun_q <= 1'b0;
        end else begin
            if (rx_push)    rx_wr_ptr <= rx_wr_ptr + 1'b1;
            if (bus.rx_ack) rx_rd_ptr <= rx_rd_ptr + 1'b1;
            if (rx_drop) begin
                rx_overrun_q <= 1'b1;
            end else if (bus.overrun_clr) begin
                rx_overrun_q <= 1'b0;
            end
        end
    end

    // Start bit is re-checked at its midpoint; all later samples land one full period apart from there.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state <= S_IDLE;
            rx_shift <= '0;
            rx_div   <= '0;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_perr  <= 1'b0;
        end else begin
            rx_cnt <= rx_bit_end ? '0 : rx_cnt + DIV_ONE;
            case (rx_state)
                S_IDLE: begin
                    rx_cnt <= '0;
                    if (rx_prev && !rx_sync) begin
                        rx_div   <= divisor;
                        rx_state <= S_START;
                    end
                end
                S_START: begin
                    if (rx_cnt == (rx_div >> 1) - DIV_ONE) begin
                        rx_cnt <= '0;
                        if (rx_sync) begin
                            rx_state <= S_IDLE;
                        end else begin
                            rx_bit   <= '0;
                            rx_perr  <= 1'b0;
                            rx_state <= S_DATA;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + DIV_ONE;
                    end
                end
                S_DATA: begin
                    if (rx_bit_end) begin
                        rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
                        if (rx_bit == LAST_DATA) begin
                            rx_state <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            rx_bit <= rx_bit + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (rx_bit_end) begin
                        rx_perr  <= (rx_sync != ((^rx_shift) ^ PAR_ODD));
                        rx_state <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (rx_bit_end) begin
                        rx_state <= S_IDLE;
                    end
                end
                default: rx_state <= S_IDLE;
            endcase
        end
    end
endmodule
